// File: rtl/round_scheduler_if.sv
// Handshake bundle between the rhythm-game flow controller and its surroundings:
// tick/key judgements in, game status and display values out.
interface round_scheduler_if;
  logic       start;
  logic       tick;
  logic       hit;
  logic       miss;
  logic       gameState;
  logic       phase;
  logic [3:0] roundTime;
  logic [3:0] roundNum;
  logic [3:0] remaining;
  logic [1:0] lives;
  logic [7:0] score;
  logic       roundStart;
  logic       gameOver;

  modport master (
    output start, tick, hit, miss,
    input  gameState, phase, roundTime, roundNum, remaining, lives, score,
           roundStart, gameOver
  );

  modport slave (
    input  start, tick, hit, miss,
    output gameState, phase, roundTime, roundNum, remaining, lives, score,
           roundStart, gameOver
  );
endinterface

// File: rtl/round_scheduler.sv
// Game-flow controller: sequences ROUND/REST windows, shortens the round window
// as rounds are completed, and tracks round number, score and lives.
module round_scheduler #(
  parameter int ROUNDS        = 10,
  parameter int START_TIME    = 8,
  parameter int MIN_TIME      = 2,
  parameter int REST_TIME     = 4,
  parameter int LIVES         = 3,
  parameter int SPEEDUP_EVERY = 2
) (
  input  logic              clk,
  input  logic              reset,
  round_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_REST, S_OVER} state_t;

  localparam logic [3:0] ROUNDS_C = 4'(ROUNDS);
  localparam logic [3:0] START_C  = 4'(START_TIME);
  localparam logic [3:0] MIN_C    = 4'(MIN_TIME);
  localparam logic [3:0] REST_C   = 4'(REST_TIME);
  localparam logic [3:0] SPD_C    = 4'(SPEEDUP_EVERY);
  localparam logic [1:0] LIVES_C  = 2'(LIVES);

  state_t     state_q, state_d;
  logic [3:0] round_time_q, round_time_d;
  logic [3:0] round_num_q, round_num_d;
  logic [3:0] remaining_q, remaining_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [3:0] spd_q, spd_d;
  logic       round_start_q, round_start_d;
  logic       game_state_q, game_state_d;
  logic       phase_q, phase_d;
  logic       game_over_q, game_over_d;

  logic [3:0] spd_inc;
  logic       speedup;
  logic [3:0] rt_dec;
  logic       lose;

  always_comb begin
    state_d       = state_q;
    round_time_d  = round_time_q;
    round_num_d   = round_num_q;
    remaining_d   = remaining_q;
    lives_d       = lives_q;
    score_d       = score_q;
    spd_d         = spd_q;
    round_start_d = 1'b0;

    spd_inc = spd_q + 4'd1;
    speedup = (spd_inc == SPD_C);
    rt_dec  = (round_time_q > MIN_C) ? round_time_q - 4'd1 : MIN_C;
    // A timeout is treated as a miss; miss outranks a coincident hit.
    lose    = bus.miss | (~bus.hit & bus.tick & (remaining_q == 4'd1));

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d       = S_ROUND;
          round_num_d   = 4'd1;
          round_time_d  = START_C;
          remaining_d   = START_C;
          lives_d       = LIVES_C;
          score_d       = '0;
          spd_d         = '0;
          round_start_d = 1'b1;
        end
      end
      S_ROUND: begin
        if (lose) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d     = S_OVER;
            remaining_d = '0;
          end else begin
            state_d     = S_REST;
            remaining_d = REST_C;
          end
        end else if (bus.hit) begin
          score_d     = (score_q == '1) ? score_q : score_q + 8'd1;
          state_d     = S_REST;
          remaining_d = REST_C;
        end else if (bus.tick && remaining_q != '0) begin
          remaining_d = remaining_q - 4'd1;
        end
      end
      S_REST: begin
        if (bus.tick) begin
          if (remaining_q == 4'd1) begin
            if (round_num_q == ROUNDS_C) begin
              state_d     = S_OVER;
              remaining_d = '0;
            end else begin
              spd_d         = speedup ? '0 : spd_inc;
              round_time_d  = speedup ? rt_dec : round_time_q;
              remaining_d   = speedup ? rt_dec : round_time_q;
              round_num_d   = round_num_q + 4'd1;
              state_d       = S_ROUND;
              round_start_d = 1'b1;
            end
          end else if (remaining_q != '0) begin
            remaining_d = remaining_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    game_state_d = (state_d == S_ROUND) || (state_d == S_REST);
    phase_d      = (state_d == S_ROUND);
    game_over_d  = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      round_time_q  <= START_C;
      round_num_q   <= '0;
      remaining_q   <= '0;
      lives_q       <= LIVES_C;
      score_q       <= '0;
      spd_q         <= '0;
      round_start_q <= 1'b0;
      game_state_q  <= 1'b0;
      phase_q       <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_time_q  <= round_time_d;
      round_num_q   <= round_num_d;
      remaining_q   <= remaining_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      spd_q         <= spd_d;
      round_start_q <= round_start_d;
      game_state_q  <= game_state_d;
      phase_q       <= phase_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.gameState  = game_state_q;
  assign bus.phase      = phase_q;
  assign bus.roundTime  = round_time_q;
  assign bus.roundNum   = round_num_q;
  assign bus.remaining  = remaining_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.roundStart = round_start_q;
  assign bus.gameOver   = game_over_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Bench for round_scheduler: a default instance and a fast-speedup instance
// checked every cycle against a window-arithmetic game model plus literal expectations.
module tb_round_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  round_scheduler_if bus_a ();
  round_scheduler_if bus_b ();

  round_scheduler #(.ROUNDS(10), .START_TIME(8), .MIN_TIME(2), .REST_TIME(4),
                    .LIVES(3), .SPEEDUP_EVERY(2))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  round_scheduler #(.ROUNDS(10), .START_TIME(7), .MIN_TIME(6), .REST_TIME(4),
                    .LIVES(3), .SPEEDUP_EVERY(1))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  localparam int M_IDLE = 0, M_ROUND = 1, M_REST = 2, M_OVER = 3;
  localparam int F_GS = 0, F_PH = 1, F_RT = 2, F_RN = 3, F_REM = 4,
                 F_LIV = 5, F_SC = 6, F_RS = 7, F_GO = 8, NF = 9;

  function automatic string fname(int f);
    case (f)
      F_GS: return "gameState";   F_PH: return "phase";
      F_RT: return "roundTime";   F_RN: return "roundNum";
      F_REM: return "remaining";  F_LIV: return "lives";
      F_SC: return "score";       F_RS: return "roundStart";
      default: return "gameOver";
    endcase
  endfunction

  function automatic int p_start(int i); return (i == 0) ? 8 : 7; endfunction
  function automatic int p_min(int i);   return (i == 0) ? 2 : 6; endfunction
  function automatic int p_se(int i);    return (i == 0) ? 2 : 1; endfunction
  localparam int P_ROUNDS = 10, P_REST = 4, P_LIVES = 3;

  // Model: the round window is a closed-form function of the round number.
  int m_mode[2], m_rnd[2], m_lives[2], m_score[2], m_el[2];
  bit m_rs[2];
  bit m_valid[2] = '{1'b0, 1'b0};

  function automatic int win_len(int i, int rnd);
    int t;
    t = p_start(i) - ((rnd > 0) ? (rnd - 1) / p_se(i) : 0);
    return (t < p_min(i)) ? p_min(i) : t;
  endfunction

  task automatic model_step(int i, bit r, bit s, bit t, bit h, bit m);
    m_rs[i] = 1'b0;
    if (r) begin
      m_valid[i] = 1'b1;
      m_mode[i] = M_IDLE; m_rnd[i] = 0; m_lives[i] = P_LIVES; m_score[i] = 0; m_el[i] = 0;
    end else begin
      case (m_mode[i])
        M_IDLE, M_OVER: if (s) begin
          m_mode[i] = M_ROUND; m_rnd[i] = 1; m_lives[i] = P_LIVES;
          m_score[i] = 0; m_el[i] = 0; m_rs[i] = 1'b1;
        end
        M_ROUND: begin
          if (m || (!h && t && m_el[i] == win_len(i, m_rnd[i]) - 1)) begin
            m_lives[i]--;
            m_mode[i] = (m_lives[i] == 0) ? M_OVER : M_REST;
            m_el[i] = 0;
          end else if (h) begin
            m_score[i] = (m_score[i] >= 255) ? 255 : m_score[i] + 1;
            m_mode[i] = M_REST; m_el[i] = 0;
          end else if (t) m_el[i]++;
        end
        default: if (t) begin
          m_el[i]++;
          if (m_el[i] == P_REST) begin
            m_el[i] = 0;
            if (m_rnd[i] == P_ROUNDS) m_mode[i] = M_OVER;
            else begin m_rnd[i]++; m_mode[i] = M_ROUND; m_rs[i] = 1'b1; end
          end
        end
      endcase
    end
  endtask

  function automatic int model_out(int i, int f);
    case (f)
      F_GS:  return (m_mode[i] == M_ROUND || m_mode[i] == M_REST) ? 1 : 0;
      F_PH:  return (m_mode[i] == M_ROUND) ? 1 : 0;
      F_RT:  return win_len(i, m_rnd[i]);
      F_RN:  return m_rnd[i];
      F_REM: return (m_mode[i] == M_ROUND) ? win_len(i, m_rnd[i]) - m_el[i] :
                    (m_mode[i] == M_REST)  ? P_REST - m_el[i] : 0;
      F_LIV: return m_lives[i];
      F_SC:  return m_score[i];
      F_RS:  return int'(m_rs[i]);
      default: return (m_mode[i] == M_OVER) ? 1 : 0;
    endcase
  endfunction

  function automatic int dut_out(int i, int f);
    if (i == 0) begin
      case (f)
        F_GS: return int'(bus_a.gameState);   F_PH: return int'(bus_a.phase);
        F_RT: return int'(bus_a.roundTime);   F_RN: return int'(bus_a.roundNum);
        F_REM: return int'(bus_a.remaining);  F_LIV: return int'(bus_a.lives);
        F_SC: return int'(bus_a.score);       F_RS: return int'(bus_a.roundStart);
        default: return int'(bus_a.gameOver);
      endcase
    end
    case (f)
      F_GS: return int'(bus_b.gameState);   F_PH: return int'(bus_b.phase);
      F_RT: return int'(bus_b.roundTime);   F_RN: return int'(bus_b.roundNum);
      F_REM: return int'(bus_b.remaining);  F_LIV: return int'(bus_b.lives);
      F_SC: return int'(bus_b.score);       F_RS: return int'(bus_b.roundStart);
      default: return int'(bus_b.gameOver);
    endcase
  endfunction

  always @(posedge clk) begin
    model_step(0, rst_a, bus_a.start, bus_a.tick, bus_a.hit, bus_a.miss);
    model_step(1, rst_b, bus_b.start, bus_b.tick, bus_b.hit, bus_b.miss);
  end

  // Literal expectations posted by the stimulus, consumed at the next falling edge.
  string l_name[256];
  int    l_inst[256], l_field[256], l_val[256];
  int    l_wr = 0;
  int    l_rd = 0;

  int n_assert = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        for (int f = 0; f < NF; f++) begin
          n_assert++;
          if (dut_out(i, f) !== model_out(i, f)) begin
            n_fail++;
            $display("FAIL model_%s inst%0d t=%0t actual=%0d expected=%0d",
                     fname(f), i, $time, dut_out(i, f), model_out(i, f));
          end
        end
      end
    end
    while (l_rd < l_wr) begin
      n_assert++;
      if (dut_out(l_inst[l_rd], l_field[l_rd]) !== l_val[l_rd]) begin
        n_fail++;
        $display("FAIL %s inst%0d %s actual=%0d expected=%0d", l_name[l_rd], l_inst[l_rd],
                 fname(l_field[l_rd]), dut_out(l_inst[l_rd], l_field[l_rd]), l_val[l_rd]);
      end
      l_rd++;
    end
  end

  task automatic expect_lit(string name, int i, int f, int v);
    l_name[l_wr] = name; l_inst[l_wr] = i; l_field[l_wr] = f; l_val[l_wr] = v;
    l_wr++;
  endtask

  task automatic cyc(int i, bit s, bit t, bit h, bit m);
    if (i == 0) begin
      bus_a.start = s; bus_a.tick = t; bus_a.hit = h; bus_a.miss = m;
    end else begin
      bus_b.start = s; bus_b.tick = t; bus_b.hit = h; bus_b.miss = m;
    end
    @(posedge clk);
    #1;
    bus_a.start = 0; bus_a.tick = 0; bus_a.hit = 0; bus_a.miss = 0;
    bus_b.start = 0; bus_b.tick = 0; bus_b.hit = 0; bus_b.miss = 0;
  endtask

  task automatic ticks(int i, int n, int gap);
    for (int k = 0; k < n; k++) begin
      cyc(i, 0, 1, 0, 0);
      for (int g = 0; g < gap; g++) cyc(i, 0, 0, 0, 0);
    end
  endtask

  int rt_tab_a[10] = '{8, 8, 7, 7, 6, 6, 5, 5, 4, 4};
  int rt_tab_b[5]  = '{7, 6, 6, 6, 6};

  initial begin
    rst_a = 1; rst_b = 1;
    bus_a.start = 0; bus_a.tick = 0; bus_a.hit = 0; bus_a.miss = 0;
    bus_b.start = 0; bus_b.tick = 0; bus_b.hit = 0; bus_b.miss = 0;
    repeat (2) @(posedge clk);
    #1; rst_a = 0; rst_b = 0;
    expect_lit("reset", 0, F_GS, 0);  expect_lit("reset", 0, F_RN, 0);
    expect_lit("reset", 0, F_LIV, 3); expect_lit("reset", 0, F_RT, 8);
    expect_lit("reset", 0, F_REM, 0); expect_lit("reset", 0, F_GO, 0);

    // Start with coincident tick; first round times out after 8 ticks.
    cyc(0, 1, 1, 0, 0);
    expect_lit("start", 0, F_REM, 8); expect_lit("start", 0, F_RS, 1);
    expect_lit("start", 0, F_PH, 1);  expect_lit("start", 0, F_RN, 1);
    ticks(0, 7, 1);
    expect_lit("tick7", 0, F_REM, 1); expect_lit("tick7", 0, F_LIV, 3);
    ticks(0, 1, 0);
    expect_lit("timeout", 0, F_LIV, 2); expect_lit("timeout", 0, F_PH, 0);
    expect_lit("timeout", 0, F_REM, 4);
    ticks(0, 4, 0);
    expect_lit("round2", 0, F_RN, 2); expect_lit("round2", 0, F_RS, 1);
    expect_lit("round2", 0, F_REM, 8);
    cyc(0, 0, 0, 0, 0);
    expect_lit("rs_pulse", 0, F_RS, 0);

    // hit and miss together: miss wins.
    cyc(0, 0, 0, 1, 1);
    expect_lit("hitmiss", 0, F_LIV, 1); expect_lit("hitmiss", 0, F_SC, 0);
    ticks(0, 4, 0);
    expect_lit("round3", 0, F_RT, 7); expect_lit("round3", 0, F_REM, 7);
    cyc(0, 0, 0, 1, 0);
    expect_lit("hit", 0, F_SC, 1); expect_lit("hit", 0, F_PH, 0);
    ticks(0, 4, 0); cyc(0, 0, 0, 1, 0);
    ticks(0, 4, 0); cyc(0, 0, 0, 1, 0);
    ticks(0, 4, 0); ticks(0, 2, 0);
    expect_lit("midgame", 0, F_SC, 3); expect_lit("midgame", 0, F_LIV, 1);
    expect_lit("midgame", 0, F_RN, 6); expect_lit("midgame", 0, F_RT, 6);

    // Reset overrides a simultaneous start.
    rst_a = 1; cyc(0, 1, 1, 0, 0); rst_a = 0;
    expect_lit("midreset", 0, F_GS, 0);  expect_lit("midreset", 0, F_SC, 0);
    expect_lit("midreset", 0, F_LIV, 3); expect_lit("midreset", 0, F_RT, 8);

    // Win every round.
    cyc(0, 1, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      expect_lit("winall_rt", 0, F_RT, rt_tab_a[r]);
      expect_lit("winall_rn", 0, F_RN, r + 1);
      cyc(0, 0, 0, 1, 0);
      ticks(0, 4, 0);
    end
    expect_lit("winall_end", 0, F_GO, 1);  expect_lit("winall_end", 0, F_SC, 10);
    expect_lit("winall_end", 0, F_REM, 0); expect_lit("winall_end", 0, F_GS, 0);
    cyc(0, 0, 1, 1, 1);
    expect_lit("over_hold", 0, F_SC, 10); expect_lit("over_hold", 0, F_LIV, 3);
    expect_lit("over_hold", 0, F_RN, 10);

    // Three timeouts end the game.
    cyc(0, 1, 0, 0, 0);
    ticks(0, 8, 0); ticks(0, 4, 0);
    ticks(0, 8, 0); ticks(0, 4, 0);
    ticks(0, 7, 0);
    expect_lit("lost", 0, F_LIV, 0); expect_lit("lost", 0, F_GS, 0);
    expect_lit("lost", 0, F_GO, 1);  expect_lit("lost", 0, F_RN, 3);
    cyc(0, 1, 1, 0, 0);
    expect_lit("restart", 0, F_RN, 1);  expect_lit("restart", 0, F_LIV, 3);
    expect_lit("restart", 0, F_REM, 8); expect_lit("restart", 0, F_GO, 0);

    // Fast-speedup instance clamps at its floor.
    cyc(1, 1, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      expect_lit("floor_rt", 1, F_RT, rt_tab_b[r]);
      cyc(1, 0, 0, 1, 0);
      ticks(1, 4, 0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
